// File: rtl/periph_slot_demux.sv
// rtl/periph_slot_demux.sv - address-slot demultiplexer from one master to NB_SPERIPHS peripheral slots
module periph_slot_demux #(
  parameter int                         NB_SPERIPHS  = 11,
  parameter int                         ADDR_WIDTH   = 32,
  parameter int                         DATA_WIDTH   = 32,
  parameter int                         ID_WIDTH     = 5,
  parameter int                         SLOT_LSB     = 10,
  parameter int                         SLOT_BITS    = 4,
  parameter logic [NB_SPERIPHS-1:0]     SLOT_EN_MASK = '1,
  parameter int                         TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0]      ERR_DATA     = DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              mst_req_i,
  input  logic [ADDR_WIDTH-1:0]             mst_add_i,
  input  logic                              mst_wen_i,
  input  logic [DATA_WIDTH-1:0]             mst_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]           mst_be_i,
  input  logic [ID_WIDTH-1:0]               mst_id_i,
  output logic                              mst_gnt_o,
  output logic                              mst_r_valid_o,
  output logic [DATA_WIDTH-1:0]             mst_r_rdata_o,
  output logic                              mst_r_opc_o,
  output logic [ID_WIDTH-1:0]               mst_r_id_o,
  output logic [NB_SPERIPHS-1:0]            slv_req_o,
  output logic [ADDR_WIDTH-1:0]             slv_add_o,
  output logic                              slv_wen_o,
  output logic [DATA_WIDTH-1:0]             slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           slv_be_o,
  output logic [ID_WIDTH-1:0]               slv_id_o,
  input  logic [NB_SPERIPHS-1:0]            slv_gnt_i,
  input  logic [NB_SPERIPHS-1:0]            slv_r_valid_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0] slv_r_rdata_i,
  input  logic [NB_SPERIPHS-1:0]            slv_r_opc_i,
  output logic [15:0]                       err_count_o,
  output logic                              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]            state;
  logic [SLOT_BITS-1:0]  slot;
  logic [SLOT_BITS-1:0]  sel_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [CNT_W-1:0]      cnt;
  logic                  mapped;
  logic                  sel_gnt;
  logic                  rsp_valid;
  logic                  rsp_opc;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign slot = mst_add_i[SLOT_LSB +: SLOT_BITS];

  // Request fields are broadcast; only slv_req_o selects the target.
  assign slv_add_o   = mst_add_i;
  assign slv_wen_o   = mst_wen_i;
  assign slv_wdata_o = mst_wdata_i;
  assign slv_be_o    = mst_be_i;
  assign slv_id_o    = mst_id_i;

  // Decode the addressed slot: populated-slot check and its grant line.
  always_comb begin
    mapped  = 1'b0;
    sel_gnt = 1'b0;
    for (int i = 0; i < NB_SPERIPHS; i++) begin
      if (slot == SLOT_BITS'(i)) begin
        mapped  = SLOT_EN_MASK[i];
        sel_gnt = slv_gnt_i[i];
      end
    end
  end

  // Route the request only in IDLE; unmapped slots are granted locally.
  always_comb begin
    slv_req_o = '0;
    mst_gnt_o = 1'b0;
    if (!rst_i && state == ST_IDLE) begin
      if (mapped) begin
        for (int i = 0; i < NB_SPERIPHS; i++) begin
          slv_req_o[i] = mst_req_i && (slot == SLOT_BITS'(i));
        end
        mst_gnt_o = sel_gnt;
      end else begin
        mst_gnt_o = mst_req_i;
      end
    end
  end

  // Pick the response lines of the slot that owns the outstanding transaction.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_opc   = 1'b0;
    rsp_data  = '0;
    for (int i = 0; i < NB_SPERIPHS; i++) begin
      if (sel_q == SLOT_BITS'(i)) begin
        rsp_valid = slv_r_valid_i[i];
        rsp_opc   = slv_r_opc_i[i];
        rsp_data  = slv_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transaction FSM; an unmapped access drives its error response during the ERR cycle itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      sel_q         <= '0;
      id_q          <= '0;
      cnt           <= '0;
      err_count_o   <= '0;
      mst_r_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      mst_r_rdata_o <= '0;
      mst_r_opc_o   <= 1'b0;
      mst_r_id_o    <= '0;
    end else begin
      mst_r_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mst_req_i) begin
            if (!mapped) begin
              state         <= ST_ERR;
              mst_r_valid_o <= 1'b1;
              mst_r_opc_o   <= 1'b1;
              mst_r_rdata_o <= ERR_DATA;
              mst_r_id_o    <= mst_id_i;
              if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            end else if (sel_gnt) begin
              state <= ST_WAIT;
              sel_q <= slot;
              id_q  <= mst_id_i;
              cnt   <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            state         <= ST_IDLE;
            mst_r_valid_o <= 1'b1;
            mst_r_opc_o   <= rsp_opc;
            mst_r_rdata_o <= rsp_data;
            mst_r_id_o    <= id_q;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state         <= ST_IDLE;
            mst_r_valid_o <= 1'b1;
            mst_r_opc_o   <= 1'b1;
            mst_r_rdata_o <= ERR_DATA;
            mst_r_id_o    <= id_q;
            timeout_o     <= 1'b1;
            if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_slot_demux.sv
// tb/tb_periph_slot_demux.sv - directed self-checking bench for periph_slot_demux
module tb_periph_slot_demux;
  localparam int NB = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mst_req;
  logic [31:0]   mst_add;
  logic          mst_wen;
  logic [31:0]   mst_wdata;
  logic [3:0]    mst_be;
  logic [4:0]    mst_id;
  logic          mst_gnt;
  logic          mst_r_valid;
  logic [31:0]   mst_r_rdata;
  logic          mst_r_opc;
  logic [4:0]    mst_r_id;
  logic [NB-1:0] slv_req;
  logic [31:0]   slv_add;
  logic          slv_wen;
  logic [31:0]   slv_wdata;
  logic [3:0]    slv_be;
  logic [4:0]    slv_id;
  logic [NB-1:0] slv_gnt;
  logic [NB-1:0] slv_r_valid;
  logic [NB*DW-1:0] slv_r_rdata;
  logic [NB-1:0] slv_r_opc;
  logic [15:0]   err_count;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  periph_slot_demux #(
    .NB_SPERIPHS (NB),
    .SLOT_EN_MASK(11'h7F7),
    .TIMEOUT     (4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(mst_req), .mst_add_i(mst_add), .mst_wen_i(mst_wen), .mst_wdata_i(mst_wdata),
    .mst_be_i(mst_be), .mst_id_i(mst_id), .mst_gnt_o(mst_gnt),
    .mst_r_valid_o(mst_r_valid), .mst_r_rdata_o(mst_r_rdata), .mst_r_opc_o(mst_r_opc), .mst_r_id_o(mst_r_id),
    .slv_req_o(slv_req), .slv_add_o(slv_add), .slv_wen_o(slv_wen), .slv_wdata_o(slv_wdata),
    .slv_be_o(slv_be), .slv_id_o(slv_id), .slv_gnt_i(slv_gnt), .slv_r_valid_i(slv_r_valid),
    .slv_r_rdata_i(slv_r_rdata), .slv_r_opc_i(slv_r_opc),
    .err_count_o(err_count), .timeout_o(timeout)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mst_req = 1'b0; mst_add = '0; mst_wen = 1'b0; mst_wdata = '0; mst_be = '0; mst_id = '0;
    slv_gnt = '0; slv_r_valid = '0; slv_r_rdata = '0; slv_r_opc = '0;
  endtask

  task automatic issue(input logic [31:0] add, input logic [4:0] id, input logic wen);
    mst_req = 1'b1; mst_add = add; mst_id = id; mst_wen = wen;
    mst_wdata = 32'hCAFE0000 | 32'(id); mst_be = 4'hF;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    issue(32'h0000_0400, 5'd1, 1'b1);
    slv_gnt = '1;
    step(); step(); #1;
    checks++; if (mst_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%0h exp=0", mst_gnt); end
    checks++; if (slv_req !== 11'h000) begin errors++; $display("FAIL rst_slv_req got=%0h exp=0", slv_req); end
    checks++; if ({mst_r_valid, mst_r_opc, timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%0b exp=000", {mst_r_valid, mst_r_opc, timeout}); end
    checks++; if (mst_r_rdata !== 32'h0 || mst_r_id !== 5'd0) begin errors++; $display("FAIL rst_rdata_id got=%0h/%0h exp=0/0", mst_r_rdata, mst_r_id); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    idle_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    issue(32'h0000_1800, 5'd5, 1'b1);
    slv_gnt[6] = 1'b1;
    #1;
    checks++; if (slv_req !== 11'h040) begin errors++; $display("FAIL rd_slv_req got=%0h exp=040", slv_req); end
    checks++; if (mst_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%0h exp=1", mst_gnt); end
    checks++; if (slv_add !== 32'h1800 || slv_id !== 5'd5 || slv_wen !== 1'b1 || slv_wdata !== 32'hCAFE0005 || slv_be !== 4'hF)
      begin errors++; $display("FAIL rd_broadcast got=%0h/%0h/%0h/%0h/%0h exp=1800/5/1/cafe0005/f", slv_add, slv_id, slv_wen, slv_wdata, slv_be); end
    step();
    // Waiting: a new request to slot 0 must not be routed or granted.
    issue(32'h0000_0000, 5'd9, 1'b1);
    slv_gnt = 11'h001;
    #1;
    checks++; if (slv_req !== 11'h000 || mst_gnt !== 1'b0) begin errors++; $display("FAIL rd_wait_block got=%0h/%0h exp=0/0", slv_req, mst_gnt); end
    step();
    idle_inputs();
    slv_r_valid = 11'h060;
    slv_r_rdata[6*DW +: DW] = 32'h0000_1234;
    slv_r_rdata[5*DW +: DW] = 32'h5555_5555;
    slv_r_opc[5] = 1'b1;
    #1;
    checks++; if (mst_r_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got=%0h exp=0", mst_r_valid); end
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_rdata !== 32'h1234 || mst_r_opc !== 1'b0 || mst_r_id !== 5'd5)
      begin errors++; $display("FAIL rd_resp got=%0h/%0h/%0h/%0h exp=1/1234/0/5", mst_r_valid, mst_r_rdata, mst_r_opc, mst_r_id); end
    step();
    checks++; if (mst_r_valid !== 1'b0 || mst_r_rdata !== 32'h1234 || mst_r_id !== 5'd5)
      begin errors++; $display("FAIL rd_hold got=%0h/%0h/%0h exp=0/1234/5", mst_r_valid, mst_r_rdata, mst_r_id); end
  endtask

  task automatic test_unmapped();
    issue(32'h0000_3000, 5'd7, 1'b0);
    slv_gnt = '1;
    #1;
    checks++; if (slv_req !== 11'h000 || mst_gnt !== 1'b1) begin errors++; $display("FAIL um_route got=%0h/%0h exp=0/1", slv_req, mst_gnt); end
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_opc !== 1'b1 || mst_r_rdata !== 32'hBADACCE5 || mst_r_id !== 5'd7)
      begin errors++; $display("FAIL um_resp got=%0h/%0h/%0h/%0h exp=1/1/badacce5/7", mst_r_valid, mst_r_opc, mst_r_rdata, mst_r_id); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL um_err_count got=%0d exp=1", err_count); end
    step();
  endtask

  task automatic test_mask();
    issue(32'h0000_0C00, 5'd9, 1'b1);
    slv_gnt = '1;
    #1;
    checks++; if (slv_req !== 11'h000 || mst_gnt !== 1'b1) begin errors++; $display("FAIL mask3_route got=%0h/%0h exp=0/1", slv_req, mst_gnt); end
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_opc !== 1'b1 || mst_r_rdata !== 32'hBADACCE5 || mst_r_id !== 5'd9 || err_count !== 16'd2)
      begin errors++; $display("FAIL mask3_resp got=%0h/%0h/%0h/%0h/%0d exp=1/1/badacce5/9/2", mst_r_valid, mst_r_opc, mst_r_rdata, mst_r_id, err_count); end
    step();
    issue(32'h0000_1000, 5'd10, 1'b1);
    slv_gnt[4] = 1'b1;
    #1;
    checks++; if (slv_req !== 11'h010 || mst_gnt !== 1'b1) begin errors++; $display("FAIL mask4_route got=%0h/%0h exp=010/1", slv_req, mst_gnt); end
    step();
    idle_inputs();
    slv_r_valid[4] = 1'b1;
    slv_r_opc[4] = 1'b1;
    slv_r_rdata[4*DW +: DW] = 32'hA5A5_0004;
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_opc !== 1'b1 || mst_r_rdata !== 32'hA5A50004 || mst_r_id !== 5'd10)
      begin errors++; $display("FAIL mask4_resp got=%0h/%0h/%0h/%0h exp=1/1/a5a50004/a", mst_r_valid, mst_r_opc, mst_r_rdata, mst_r_id); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL slave_opc_not_counted got=%0d exp=2", err_count); end
    step();
  endtask

  task automatic test_timeout();
    issue(32'h0000_0800, 5'd3, 1'b1);
    slv_gnt[2] = 1'b1;
    step();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (mst_r_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_early_c%0d got=%0h/%0h exp=0/0", c, mst_r_valid, timeout); end
      step();
    end
    #1;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%0h exp=1", timeout); end
    checks++; if (mst_r_valid !== 1'b1 || mst_r_opc !== 1'b1 || mst_r_rdata !== 32'hBADACCE5 || mst_r_id !== 5'd3 || err_count !== 16'd3)
      begin errors++; $display("FAIL to_resp got=%0h/%0h/%0h/%0h/%0d exp=1/1/badacce5/3/3", mst_r_valid, mst_r_opc, mst_r_rdata, mst_r_id, err_count); end
    slv_r_valid[2] = 1'b1;
    slv_r_rdata[2*DW +: DW] = 32'h0BAD_0002;
    step();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (mst_r_valid !== 1'b0 || timeout !== 1'b0 || err_count !== 16'd3)
        begin errors++; $display("FAIL to_late_drop_%0d got=%0h/%0h/%0d exp=0/0/3", c, mst_r_valid, timeout, err_count); end
      step();
    end
  endtask

  task automatic test_resp_beats_timeout();
    issue(32'h0000_0800, 5'd4, 1'b1);
    slv_gnt[2] = 1'b1;
    step();
    idle_inputs();
    step(); step(); step();
    slv_r_valid[2] = 1'b1;
    slv_r_rdata[2*DW +: DW] = 32'h0000_00E2;
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_opc !== 1'b0 || mst_r_rdata !== 32'hE2 || mst_r_id !== 5'd4)
      begin errors++; $display("FAIL race_resp got=%0h/%0h/%0h/%0h exp=1/0/e2/4", mst_r_valid, mst_r_opc, mst_r_rdata, mst_r_id); end
    checks++; if (timeout !== 1'b0 || err_count !== 16'd3) begin errors++; $display("FAIL race_no_timeout got=%0h/%0d exp=0/3", timeout, err_count); end
    step();
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0000, 5'd1, 1'b1);
    slv_gnt = 11'h001;
    #1;
    checks++; if (mst_gnt !== 1'b1 || slv_req !== 11'h001) begin errors++; $display("FAIL b2b_gnt0 got=%0h/%0h exp=1/001", mst_gnt, slv_req); end
    step();
    issue(32'h0000_0400, 5'd2, 1'b1);
    slv_gnt = 11'h002;
    slv_r_valid = 11'h001;
    slv_r_rdata[0*DW +: DW] = 32'h0000_0100;
    #1;
    checks++; if (mst_gnt !== 1'b0) begin errors++; $display("FAIL b2b_wait_gnt got=%0h exp=0", mst_gnt); end
    step();
    slv_r_valid = '0;
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_id !== 5'd1 || mst_r_rdata !== 32'h100)
      begin errors++; $display("FAIL b2b_resp0 got=%0h/%0h/%0h exp=1/1/100", mst_r_valid, mst_r_id, mst_r_rdata); end
    checks++; if (mst_gnt !== 1'b1 || slv_req !== 11'h002) begin errors++; $display("FAIL b2b_gnt1 got=%0h/%0h exp=1/002", mst_gnt, slv_req); end
    step();
    idle_inputs();
    slv_r_valid = 11'h002;
    slv_r_rdata[1*DW +: DW] = 32'h0000_0200;
    step();
    idle_inputs();
    #1;
    checks++; if (mst_r_valid !== 1'b1 || mst_r_id !== 5'd2 || mst_r_rdata !== 32'h200)
      begin errors++; $display("FAIL b2b_resp1 got=%0h/%0h/%0h exp=1/2/200", mst_r_valid, mst_r_id, mst_r_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_1400, 5'd6, 1'b1);
    slv_gnt[5] = 1'b1;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if ({mst_r_valid, mst_r_opc, timeout} !== 3'b000 || mst_r_rdata !== 32'h0 || mst_r_id !== 5'd0 || err_count !== 16'd0)
      begin errors++; $display("FAIL midrst_outputs got=%0b/%0h/%0h/%0d exp=000/0/0/0", {mst_r_valid, mst_r_opc, timeout}, mst_r_rdata, mst_r_id, err_count); end
    slv_r_valid[5] = 1'b1;
    slv_r_rdata[5*DW +: DW] = 32'h0000_DEAD;
    step();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (mst_r_valid !== 1'b0 || mst_r_rdata !== 32'h0) begin errors++; $display("FAIL midrst_late_drop_%0d got=%0h/%0h exp=0/0", c, mst_r_valid, mst_r_rdata); end
      step();
    end
    idle_inputs();
    issue(32'h0000_1C00, 5'd8, 1'b1);
    slv_gnt[7] = 1'b1;
    #1;
    checks++; if (mst_gnt !== 1'b1 || slv_req !== 11'h080) begin errors++; $display("FAIL midrst_idle got=%0h/%0h exp=1/080", mst_gnt, slv_req); end
    step();
    idle_inputs();
    slv_r_valid[7] = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    test_reset();
    test_read();
    test_unmapped();
    test_mask();
    test_timeout();
    test_resp_beats_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/periph_slot_demux.md
PERIPH_SLOT_DEMUX -- requirements
Module: periph_slot_demux

Interface
REQ-001 Parameters SHALL be: NB_SPERIPHS=11 (slave slots); ADDR_WIDTH=32; DATA_WIDTH=32; ID_WIDTH=5; SLOT_LSB=10 (lowest slot-select address bit); SLOT_BITS=4 (slot-select width); SLOT_EN_MASK=all ones, NB_SPERIPHS bits (1 = slot populated); TIMEOUT=255 (max response wait, cycles, >=1); ERR_DATA=32'hBADACCE5 (error read data).
REQ-002 Clocking SHALL be one clock; reset synchronous, active-high.
REQ-003 Ports SHALL be: clk_i in 1 clock; rst_i in 1 sync active-high reset.
REQ-004 Ports SHALL be: mst_req_i in 1; mst_add_i in ADDR_WIDTH; mst_wen_i in 1 (1=read); mst_wdata_i in DATA_WIDTH; mst_be_i in DATA_WIDTH/8; mst_id_i in ID_WIDTH; mst_gnt_o out 1.
REQ-005 Ports SHALL be: mst_r_valid_o out 1; mst_r_rdata_o out DATA_WIDTH; mst_r_opc_o out 1 (1=error); mst_r_id_o out ID_WIDTH.
REQ-006 Per-slot ports SHALL be: slv_req_o out NB_SPERIPHS; slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_id_o out (shared, broadcast of master fields); slv_gnt_i in NB_SPERIPHS; slv_r_valid_i in NB_SPERIPHS; slv_r_rdata_i in NB_SPERIPHS x DATA_WIDTH; slv_r_opc_i in NB_SPERIPHS.
REQ-007 Status ports SHALL be: err_count_o out 16 (saturating error count); timeout_o out 1 (one-cycle pulse).

Function
REQ-010 Slot index s SHALL equal mst_add_i[SLOT_LSB +: SLOT_BITS]; s is mapped iff s < NB_SPERIPHS and SLOT_EN_MASK[s]=1.
REQ-011 FSM states SHALL be IDLE, WAIT, ERR; one transaction outstanding at a time.
REQ-012 IDLE, mapped s: slv_req_o[s]=mst_req_i combinationally, all other slv_req_o bits 0, mst_gnt_o=slv_gnt_i[s]; on req&gnt capture s and mst_id_i, clear timeout counter, go WAIT.
REQ-013 IDLE, unmapped s, mst_req_i=1: no slv_req_o asserted; mst_gnt_o=1 same cycle; capture id; go ERR.
REQ-014 WAIT and ERR: all slv_req_o=0 and mst_gnt_o=0.
REQ-015 WAIT: slv_r_valid_i[captured s]=1 -> register rdata/opc, next cycle mst_r_valid_o=1 for exactly one cycle with captured id; go IDLE.
REQ-016 WAIT: counter increments each cycle without response; on reaching TIMEOUT with no response -> next cycle mst_r_valid_o=1, opc=1, rdata=ERR_DATA, timeout_o=1 one cycle; go IDLE.
REQ-017 Response and timeout in the same cycle: response SHALL win; no timeout pulse, no error count.
REQ-018 ERR: next cycle (one cycle after grant) mst_r_valid_o=1, opc=1, rdata=ERR_DATA; go IDLE.
REQ-019 slv_r_valid_i from non-selected slots, or arriving in IDLE/ERR (late response after timeout), SHALL be dropped silently.
REQ-020 IDLE MAY grant a new request in the same cycle mst_r_valid_o is high (back-to-back: one transaction per 2 cycles minimum for a zero-latency slave).
REQ-021 mst_r_rdata_o/opc_o/id_o SHALL hold their last value when mst_r_valid_o=0.
REQ-022 err_count_o SHALL increment by 1 per unmapped access and per timeout, saturating at 16'hFFFF; slave-reported opc=1 responses SHALL NOT count.
REQ-023 slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_id_o SHALL be combinational copies of master inputs.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, counter 0, err_count_o=0, mst_r_valid_o=0, timeout_o=0, mst_r_rdata_o=0, mst_r_opc_o=0, mst_r_id_o=0.
REQ-031 Reset mid-transaction (WAIT/ERR) SHALL abandon it with no response; subsequent late slave response SHALL be dropped.
REQ-032 While rst_i=1, mst_gnt_o and all slv_req_o SHALL be 0.

Verification
REQ-040 Read 0x0000_1800 (slot 6), slave 6 gnt same cycle, r_valid 2 cycles later rdata=0x1234 -> mst_r_valid 1 cycle after, rdata=0x1234, opc=0, id matches.
REQ-041 Write to slot 12 (unmapped) -> mst_gnt same cycle, next cycle r_valid, opc=1, rdata=0xBADACCE5, err_count_o=1; no slv_req_o asserted.
REQ-042 SLOT_EN_MASK bit 3 = 0, access slot 3 -> error response as REQ-041; slot 4 access still routed normally.
REQ-043 TIMEOUT=4, slot 2 granted, never responds -> timeout_o pulse, error response 5 cycles after grant; later slave 2 r_valid dropped; err_count_o=1.
REQ-044 Back-to-back reads slots 0,1 with zero-latency slaves -> second gnt in the cycle first r_valid is high, ids returned in order.
REQ-045 rst_i asserted in WAIT -> next cycle IDLE, all outputs at reset values; slave response afterwards produces no mst_r_valid_o.
